// File: rtl/mul_dot_ctrl.sv
// Dot-product sequencer for an 8x8 shift-add multiplier: fetches operand pairs,
// issues them one at a time and accumulates the products. Optional macro MUL_DOT_CTRL_SAT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for start_i
// FETCH     | op_ready_o high, waiting for an operand pair
// ISSUE     | pulse mul_start_o once the multiplier is free
// WAIT_ACK  | waiting for mul_busy_i to rise
// WAIT_DONE | waiting for mul_busy_i to fall
// ACCUM     | add product, count pair, publish result on last pair
module mul_dot_ctrl #(
    parameter int N_PAIRS = 4,
    parameter int ACC_W   = 18
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             busy_o,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [7:0]       op_a_bi,
    input  logic [7:0]       op_b_bi,
    output logic             mul_start_o,
    output logic [7:0]       mul_a_bo,
    output logic [7:0]       mul_b_bo,
    input  logic             mul_busy_i,
    input  logic [15:0]      mul_y_bi,
    output logic             res_valid_o,
`ifdef MUL_DOT_CTRL_SAT_EN
    output logic             ovf_o,
`endif
    output logic [ACC_W-1:0] y_bo
);

    localparam int CNT_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ACCUM
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_mul_a;
    logic [7:0]         r_mul_b;
    logic [ACC_W-1:0]   r_y;
    logic               r_res_valid;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_last;

`ifdef MUL_DOT_CTRL_SAT_EN
    logic [ACC_W:0]     w_sum;
    logic               r_ovf;

    assign w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'(mul_y_bi);
    // carry-out clamps to full scale; once there, any nonzero product carries again
    assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign ovf_o      = r_ovf;
`else
    assign w_acc_next = r_acc + ACC_W'(mul_y_bi);
`endif

    assign w_last = (r_cnt == CNT_W'(N_PAIRS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_y         <= '0;
            r_res_valid <= 1'b0;
`ifdef MUL_DOT_CTRL_SAT_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
`ifdef MUL_DOT_CTRL_SAT_EN
                        r_ovf   <= 1'b0;
`endif
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (op_valid_i) begin
                        r_mul_a <= op_a_bi;
                        r_mul_b <= op_b_bi;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!mul_busy_i) r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (mul_busy_i) r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (!mul_busy_i) r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
`ifdef MUL_DOT_CTRL_SAT_EN
                    if (w_sum[ACC_W]) r_ovf <= 1'b1;
`endif
                    if (w_last) begin
                        r_y         <= w_acc_next;
                        r_res_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state     <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // state decodes; start is gated by busy so a leftover operation holds ISSUE
    assign busy_o      = (r_state != S_IDLE);
    assign op_ready_o  = (r_state == S_FETCH);
    assign mul_start_o = (r_state == S_ISSUE) && !mul_busy_i;
    assign mul_a_bo    = r_mul_a;
    assign mul_b_bo    = r_mul_b;
    assign res_valid_o = r_res_valid;
    assign y_bo        = r_y;

endmodule

// File: tb/tb_mul_dot_ctrl.sv
// Directed bench for mul_dot_ctrl: two instances (N_PAIRS=4 and 8) each driving
// a behavioural 8-cycle shift-add multiplier model.
module tb_mul_dot_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    logic        start[2], op_valid[2], busy[2], ready[2], mstart[2];
    logic        mbusy[2], resv[2], force_busy[2];
    logic [7:0]  op_a[2], op_b[2], ma[2], mb[2];
    logic [15:0] my[2];
    logic [17:0] y[2];
`ifdef MUL_DOT_CTRL_SAT_EN
    logic        ovf[2];
`endif

    mul_dot_ctrl #(.N_PAIRS(4), .ACC_W(18)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .busy_o(busy[0]),
        .op_valid_i(op_valid[0]), .op_ready_o(ready[0]), .op_a_bi(op_a[0]), .op_b_bi(op_b[0]),
        .mul_start_o(mstart[0]), .mul_a_bo(ma[0]), .mul_b_bo(mb[0]), .mul_busy_i(mbusy[0]),
        .mul_y_bi(my[0]), .res_valid_o(resv[0]),
`ifdef MUL_DOT_CTRL_SAT_EN
        .ovf_o(ovf[0]),
`endif
        .y_bo(y[0]));

    mul_dot_ctrl #(.N_PAIRS(8), .ACC_W(18)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .busy_o(busy[1]),
        .op_valid_i(op_valid[1]), .op_ready_o(ready[1]), .op_a_bi(op_a[1]), .op_b_bi(op_b[1]),
        .mul_start_o(mstart[1]), .mul_a_bo(ma[1]), .mul_b_bo(mb[1]), .mul_busy_i(mbusy[1]),
        .mul_y_bi(my[1]), .res_valid_o(resv[1]),
`ifdef MUL_DOT_CTRL_SAT_EN
        .ovf_o(ovf[1]),
`endif
        .y_bo(y[1]));

    // multiplier model: busy high 8 cycles after start, product taken from the
    // operand bus when busy falls, so operands must stay put through WAIT_DONE
    for (genvar g = 0; g < 2; g++) begin : g_mul
        int          m_cnt  = 0;
        logic        m_busy = 1'b0;
        logic [15:0] m_y    = '0;
        always @(posedge clk) begin
            if (mstart[g] && m_cnt == 0) begin
                m_cnt  <= 8;
                m_busy <= 1'b1;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_y    <= ma[g] * mb[g];
                end
            end
        end
        assign mbusy[g] = m_busy | force_busy[g];
        assign my[g]    = m_y;
    end

    int c_busy[2], c_ready[2], c_mstart[2], c_resv[2], c_viol[2];
    initial for (int g = 0; g < 2; g++) begin
        c_busy[g] = 0; c_ready[g] = 0; c_mstart[g] = 0; c_resv[g] = 0; c_viol[g] = 0;
    end
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (busy[g])               c_busy[g]++;
            if (ready[g])              c_ready[g]++;
            if (mstart[g])             c_mstart[g]++;
            if (resv[g])               c_resv[g]++;
            if (ready[g] && mstart[g]) c_viol[g]++;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int              g;
        int              n;
        logic [7:0][7:0] a;
        logic [7:0][7:0] b;
        int              gap;
        int              mode;   // 0 plain, 1 leftover busy at ISSUE, 2 stray start_i
        logic [17:0]     exp_y;
        int              exp_busy;
        logic            exp_ovf;
    } vec_t;

    function automatic vec_t mk(int g, int n, logic [63:0] a, logic [63:0] b, int gap,
                                int mode, logic [17:0] ey, int eb, logic eo);
        vec_t v;
        v.g = g; v.n = n; v.a = a; v.b = b; v.gap = gap; v.mode = mode;
        v.exp_y = ey; v.exp_busy = eb; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic do_start(input int g);
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
    endtask

    task automatic send(input int g, input logic [7:0] a, input logic [7:0] b,
                        input int gap, input int mode, input int i);
        int t = 0;
        @(negedge clk);
        while (!ready[g] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready[g]) begin
            chk("fetch_timeout", 32'(ready[g]), 1);
            return;
        end
        for (int k = 0; k < gap; k++) begin
            if (mode == 2 && i == 1 && k == 0) start[g] = 1'b1;
            @(posedge clk); #1 start[g] = 1'b0;
        end
        op_a[g] = a; op_b[g] = b; op_valid[g] = 1'b1;
        @(posedge clk); #1 op_valid[g] = 1'b0;
        chk("ready_low_after_accept", 32'(ready[g]), 0);
        if (mode == 1 && i == 0) begin
            force_busy[g] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk); chk("no_start_while_busy", 32'(mstart[g]), 0);
                @(posedge clk); #1;
            end
            force_busy[g] = 1'b0;
            @(negedge clk); chk("start_after_busy", 32'(mstart[g]), 1);
        end
        if (mode == 2 && i == 1) begin
            repeat (2) @(posedge clk);
            #1 start[g] = 1'b1;
            @(posedge clk); #1 start[g] = 1'b0;
        end
    endtask

    task automatic run(input vec_t v);
        int g = v.g;
        int t = 0;
        int b0, r0, s0, v0, x0;
        do_start(g);
`ifdef MUL_DOT_CTRL_SAT_EN
        if (g == 1) chk("ovf_clear_on_start", 32'(ovf[1]), 0);
`endif
        b0 = c_busy[g]; r0 = c_ready[g]; s0 = c_mstart[g]; v0 = c_resv[g]; x0 = c_viol[g];
        for (int i = 0; i < v.n; i++) send(g, v.a[i], v.b[i], v.gap, v.mode, i);
        @(negedge clk); #1;
        while (!resv[g] && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("res_valid_seen", 32'(resv[g]), 1);
        chk("y_result", 32'(y[g]), 32'(v.exp_y));
        chk("busy_low_at_result", 32'(busy[g]), 0);
`ifdef MUL_DOT_CTRL_SAT_EN
        chk("ovf_flag", 32'(ovf[g]), 32'(v.exp_ovf));
`endif
        @(negedge clk); #1;
        chk("res_valid_one_cycle", 32'(resv[g]), 0);
        chk("y_held", 32'(y[g]), 32'(v.exp_y));
        if (v.exp_busy >= 0) chk("busy_cycles", c_busy[g] - b0, v.exp_busy);
        chk("ready_cycles", c_ready[g] - r0, v.n * (v.gap + 1));
        chk("mul_start_pulses", c_mstart[g] - s0, v.n);
        chk("res_valid_count", c_resv[g] - v0, 1);
        chk("start_in_fetch", c_viol[g] - x0, 0);
    endtask

    localparam logic [63:0] A1 = {8'd10, 8'd255, 8'd2, 8'd1};
    localparam logic [63:0] B1 = {8'd20, 8'd255, 8'd3, 8'd1};
    localparam logic [63:0] A34 = {8'd3, 8'd3, 8'd3, 8'd3};
    localparam logic [63:0] B34 = {8'd4, 8'd4, 8'd4, 8'd4};
`ifdef MUL_DOT_CTRL_SAT_EN
    localparam logic [17:0] Y_FULL8 = 18'd262143;
    localparam logic        O_FULL8 = 1'b1;
`else
    localparam logic [17:0] Y_FULL8 = 18'd258056;
    localparam logic        O_FULL8 = 1'b0;
`endif

    vec_t vecs[9];

    initial begin
        vecs[0] = mk(0, 4, A1, B1, 0, 0, 18'd65232, 48, 1'b0);
        vecs[1] = mk(0, 4, A1, B1, 5, 0, 18'd65232, 68, 1'b0);
        vecs[2] = mk(0, 4, {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 0, 0, 18'd100, 48, 1'b0);
        vecs[3] = mk(0, 4, 64'd0, 64'd0, 0, 0, 18'd0, 48, 1'b0);
        vecs[4] = mk(0, 4, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 18'd260100, 48, 1'b0);
        vecs[5] = mk(0, 4, A1, B1, 0, 1, 18'd65232, 51, 1'b0);
        vecs[6] = mk(0, 4, A34, B34, 2, 2, 18'd48, 56, 1'b0);
        vecs[7] = mk(1, 8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, Y_FULL8, 96, O_FULL8);
        vecs[8] = mk(1, 8, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101, 0, 0, 18'd8, 96, 1'b0);

        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; op_valid[g] = 1'b0; op_a[g] = '0; op_b[g] = '0; force_busy[g] = 1'b0;
        end

        #1 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("reset_ctrl", {28'd0, busy[g], ready[g], mstart[g], resv[g]}, 0);
            chk("reset_operands", {16'd0, ma[g], mb[g]}, 0);
            chk("reset_y", 32'(y[g]), 0);
`ifdef MUL_DOT_CTRL_SAT_EN
            chk("reset_ovf", 32'(ovf[g]), 0);
`endif
        end
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 9; i++) run(vecs[i]);

        // async abort in WAIT_DONE of pair 2, outputs must clear before any edge
        do_start(0);
        send(0, 8'd5, 8'd6, 0, 0, 0);
        send(0, 8'd7, 8'd8, 0, 0, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("busy_before_abort", 32'(busy[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_ctrl", {28'd0, busy[0], ready[0], mstart[0], resv[0]}, 0);
        chk("abort_operands", {16'd0, ma[0], mb[0]}, 0);
        chk("abort_y", 32'(y[0]), 0);
        @(posedge clk); #1 rst = 1'b0;
        run(mk(0, 4, A34, B34, 0, 0, 18'd48, -1, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
